fft_ctrl: RTL
=============

# fft_ctrl

Sequencing controller for the 32-point radix-2 MDC FFT pipeline. It accepts a two-lane sample stream of 16 cycles per frame and tracks the frame's position through the five pipeline stages. From that it drives every stage's commutator select and twiddle-ROM counter and produces output framing (valid, start/end of frame, optional bin index). It replaces the free-running counters currently wired by hand into each stage.

## Interface
Parameters:
- FRAME_CYC, 16, cycles per 32-point frame (two samples per cycle); fixed, power of two.
- OUT_LAT, 15, input-to-output pipeline latency in cycles (8+4+2+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample pair present on the datapath input lanes this cycle.
- clear_err  in  1  clears err_gap.
- com_sel  out  4  commutator swap select; bit k-2 drives stage k (k=2..5).
- rom_16_counter  out  4  stage-1 twiddle index.
- rom_8_counter  out  3  stage-2 twiddle index.
- rom_4_counter  out  2  stage-3 twiddle index.
- rom_2_counter  out  1  stage-4 twiddle index.
- out_valid  out  1  final-stage output pair valid.
- out_sop  out  1  first output pair of a frame.
- out_eop  out  1  last output pair of a frame.
- busy  out  1  any frame in flight (input or pipeline).
- err_gap  out  1  sticky: in_valid dropped inside a frame.
- out_bin_up  out  5  bin index of the upper output lane (macro only).
- out_bin_lo  out  5  bin index of the lower output lane (macro only).

## Operation
- Stage input taps, as latency from the datapath input: L1=0, L2=0, L3=8, L4=12, L5=14, out=15.
- Stage latency: D=8,4,2,1 for stages 2..5. Stage 1 is combinational.
- cnt_in, 4 bits, is the index of the pair at the input this cycle. A frame starts when in_valid=1 with cnt_in=0.
- Once a frame has started, cnt_in advances every cycle until it wraps 15→0, regardless of in_valid. This keeps the shift registers aligned, because they have no enable.
- Each cycle pushes two bits into 15-deep token pipes: act (frame slot occupied) and val (act & in_valid).
- cnt_s: index of the pair entering stage s. Equals cnt_in delayed by L_s; implemented as a delayed 4-bit copy or as a counter advanced on the act tap.
- com_sel for stage k = cnt_k[log2 D_k], i.e. stage 2 uses bit 3 and stage 5 uses bit 0.
- Twiddle-ROM counters:
  - rom_16_counter = cnt_1.
  - rom_8_counter = cnt_2[2:0].
  - rom_4_counter = cnt_3[1:0].
  - rom_2_counter = cnt_4[0].
- Output framing, with cnt_out = cnt_in delayed by 15:
  - out_valid = val tap at 15.
  - out_sop = act tap & cnt_out==0.
  - out_eop = act tap & cnt_out==15.
- busy = (cnt_in≠0) | any act bit set.
- In-frame gap (in_valid=0 while cnt_in≠0):
  - err_gap sets on the next edge and stays set.
  - The slot continues with val=0, so out_valid is low for that pair.
  - Framing is unchanged.
- clear_err clears err_gap. A gap and clear_err in the same cycle leave err_gap set.
- No state machine beyond the frame counter and the token pipes.
- Frame-counter states:
  - IDLE: cnt_in=0 and no frame started.
  - IN_FRAME: cnt_in 1..15.
- Transitions:
  - IDLE→IN_FRAME on in_valid.
  - IN_FRAME→IDLE at wrap when in_valid=0.
  - At wrap with in_valid=1, the next frame starts back-to-back with no bubble.

## Timing
- On rst, every register clears: cnt_in, all delayed counters, token pipes, err_gap.
- Output values while rst is asserted:
  - All outputs are 0, except out_bin_lo, whose MSB is constant 1.
  - com_sel, the ROM counters and the framing outputs are 0.
- Reset mid-frame discards all in-flight frames. out_valid stays low until 15 cycles after the next frame start.
- com_sel and the ROM counters are combinational from registered state only (glitch-free). They apply to the data on the same cycle.
- Output pair of input index i appears exactly 15 cycles after that input.
- Back-to-back frames give continuous out_valid; out_eop of frame n is followed next cycle by out_sop of frame n+1.

## Configuration
- FFT_CTRL_BITREV_EN defined: out_bin_up and out_bin_lo exist.
  - out_bin_up = {1'b0, bitrev4(cnt_out)}.
  - out_bin_lo = {1'b1, bitrev4(cnt_out)}.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package fft_pkg:
  - Constants: FRAME_CYC, per-stage D and L values, OUT_LAT.
  - bitrev4 function.
- One sub-module, fft_tap_delay: a parameterised depth×width delay line. It is used for the counter copies and the token pipes.

## Test plan
- Single frame, in_valid high for 16 cycles from cycle 0:
  - rom_16_counter reads 0..15.
  - com_sel[0] is high for cycles 8..15.
  - out_sop at cycle 15, out_eop at cycle 30, busy low from cycle 31.
- Three back-to-back frames: out_valid high cycles 15..62 continuously; out_sop at 15, 31 and 47.
- in_valid low at frame index 5:
  - err_gap=1 from the next cycle.
  - out_valid low only at cycle 20; out_eop still at cycle 30.
  - clear_err then clears err_gap.
- rst asserted at frame index 9: all outputs 0 at once; a new frame afterwards gives out_sop exactly 15 cycles after its start.
- Gap and clear_err asserted in the same cycle: err_gap remains 1.
- With FFT_CTRL_BITREV_EN, at cnt_out=1: out_bin_up=8, out_bin_lo=24. At cnt_out=15: 15 and 31.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, frame-slot token type and helpers for the 32-point
// radix-2 MDC FFT sequencing controller.
package fft_pkg;

  localparam int FFT_FRAME_CYC = 16;
  localparam int FFT_CNT_W     = 4;
  localparam int FFT_OUT_LAT   = 15;

  // Per-stage delay-line depth (stages 2..5)
  localparam int FFT_D2 = 8;
  localparam int FFT_D3 = 4;
  localparam int FFT_D4 = 2;
  localparam int FFT_D5 = 1;

  // Stage input taps, latency from the datapath input
  localparam int FFT_L1 = 0;
  localparam int FFT_L2 = 0;
  localparam int FFT_L3 = 8;
  localparam int FFT_L4 = 12;
  localparam int FFT_L5 = 14;

  typedef enum logic {
    FRM_IDLE     = 1'b0,
    FRM_IN_FRAME = 1'b1
  } frm_state_e;

  // One frame slot travelling down the pipeline. cnt is only non-zero while
  // act is set, so a non-zero word means an occupied slot.
  typedef struct packed {
    logic                 act;
    logic                 val;
    logic [FFT_CNT_W-1:0] cnt;
  } tok_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Control/status bundle of fft_ctrl. The bin-index outputs exist only when
// FFT_CTRL_BITREV_EN is defined.
interface fft_ctrl_if;
  logic       in_valid;
  logic       clear_err;
  logic [3:0] com_sel;
  logic [3:0] rom_16_counter;
  logic [2:0] rom_8_counter;
  logic [1:0] rom_4_counter;
  logic       rom_2_counter;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       busy;
  logic       err_gap;
`ifdef FFT_CTRL_BITREV_EN
  logic [4:0] out_bin_up;
  logic [4:0] out_bin_lo;

  modport master (
    output in_valid, clear_err,
    input  com_sel, rom_16_counter, rom_8_counter, rom_4_counter, rom_2_counter,
    input  out_valid, out_sop, out_eop, busy, err_gap, out_bin_up, out_bin_lo
  );
  modport slave (
    input  in_valid, clear_err,
    output com_sel, rom_16_counter, rom_8_counter, rom_4_counter, rom_2_counter,
    output out_valid, out_sop, out_eop, busy, err_gap, out_bin_up, out_bin_lo
  );
`else
  modport master (
    output in_valid, clear_err,
    input  com_sel, rom_16_counter, rom_8_counter, rom_4_counter, rom_2_counter,
    input  out_valid, out_sop, out_eop, busy, err_gap
  );
  modport slave (
    input  in_valid, clear_err,
    output com_sel, rom_16_counter, rom_8_counter, rom_4_counter, rom_2_counter,
    output out_valid, out_sop, out_eop, busy, err_gap
  );
`endif
endinterface

// File: rtl/fft_tap_delay.sv
// Fixed-depth delay line without enable. o_nz flags that any stored word is
// non-zero, used to see whether a pipeline segment still holds a frame slot.
module fft_tap_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_nz
);

  logic [WIDTH-1:0] r_sr [DEPTH];
  logic             w_nz;

  // Shift one position per cycle; reset flushes every word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  // OR-reduce the whole line
  always_comb begin
    w_nz = 1'b0;
    for (int i = 0; i < DEPTH; i++) w_nz = w_nz | (|r_sr[i]);
  end

  assign o_q  = r_sr[DEPTH-1];
  assign o_nz = w_nz;

endmodule

// File: rtl/fft_ctrl.sv
// Sequencing controller for the 32-point radix-2 MDC FFT pipeline.
// Optional feature macro: FFT_CTRL_BITREV_EN adds out_bin_up/out_bin_lo.
//
// state        | meaning
// FRM_IDLE     | cnt_in = 0, no frame in progress at the input
// FRM_IN_FRAME | cnt_in = 1..15, frame running; counter advances every cycle
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int FRAME_CYC = FFT_FRAME_CYC,
  parameter int OUT_LAT   = FFT_OUT_LAT
) (
  input  logic       clk,
  input  logic       rst,
  fft_ctrl_if.slave  bus
);

  frm_state_e r_state;
  logic [3:0] r_cnt_in;
  logic       r_err_gap;

  logic       w_in_frame;
  logic       w_act;
  logic       w_gap;
  tok_t       w_tok_in;
  tok_t       w_t3, w_t4, w_t5, w_tout;
  logic [3:0] w_nz;

  assign w_in_frame = (r_state == FRM_IN_FRAME);
  assign w_act      = w_in_frame | bus.in_valid;
  assign w_gap      = w_in_frame & ~bus.in_valid;

  assign w_tok_in.act = w_act;
  assign w_tok_in.val = w_act & bus.in_valid;
  assign w_tok_in.cnt = r_cnt_in;

  // Frame counter: start on in_valid at slot 0, then free-run to the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FRM_IDLE;
      r_cnt_in <= '0;
    end else begin
      case (r_state)
        FRM_IDLE: begin
          if (bus.in_valid) begin
            r_state  <= FRM_IN_FRAME;
            r_cnt_in <= 4'd1;
          end
        end
        FRM_IN_FRAME: begin
          if (r_cnt_in == 4'(FRAME_CYC - 1)) begin
            r_state  <= FRM_IDLE;
            r_cnt_in <= '0;
          end else begin
            r_cnt_in <= r_cnt_in + 4'd1;
          end
        end
        default: begin
          r_state  <= FRM_IDLE;
          r_cnt_in <= '0;
        end
      endcase
    end
  end

  // Sticky gap flag; a gap wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_err_gap <= 1'b0;
    else if (w_gap)         r_err_gap <= 1'b1;
    else if (bus.clear_err) r_err_gap <= 1'b0;
  end

  // Token pipe split at the stage taps so each segment output is a tap
  fft_tap_delay #(.DEPTH(FFT_L3), .WIDTH($bits(tok_t))) u_seg3 (
    .clk(clk), .rst(rst), .i_d(w_tok_in), .o_q(w_t3), .o_nz(w_nz[0])
  );
  fft_tap_delay #(.DEPTH(FFT_L4 - FFT_L3), .WIDTH($bits(tok_t))) u_seg4 (
    .clk(clk), .rst(rst), .i_d(w_t3), .o_q(w_t4), .o_nz(w_nz[1])
  );
  fft_tap_delay #(.DEPTH(FFT_L5 - FFT_L4), .WIDTH($bits(tok_t))) u_seg5 (
    .clk(clk), .rst(rst), .i_d(w_t4), .o_q(w_t5), .o_nz(w_nz[2])
  );
  fft_tap_delay #(.DEPTH(OUT_LAT - FFT_L5), .WIDTH($bits(tok_t))) u_segout (
    .clk(clk), .rst(rst), .i_d(w_t5), .o_q(w_tout), .o_nz(w_nz[3])
  );

  // Stages 1 and 2 both see the input counter directly
  assign bus.com_sel = {w_t5.cnt[$clog2(FFT_D5)],
                        w_t4.cnt[$clog2(FFT_D4)],
                        w_t3.cnt[$clog2(FFT_D3)],
                        r_cnt_in[$clog2(FFT_D2)]};

  assign bus.rom_16_counter = r_cnt_in;
  assign bus.rom_8_counter  = r_cnt_in[2:0];
  assign bus.rom_4_counter  = w_t3.cnt[1:0];
  assign bus.rom_2_counter  = w_t4.cnt[0];

  assign bus.out_valid = w_tout.val;
  assign bus.out_sop   = w_tout.act & (w_tout.cnt == 4'd0);
  assign bus.out_eop   = w_tout.act & (w_tout.cnt == 4'(FRAME_CYC - 1));
  assign bus.busy      = w_in_frame | (|w_nz);
  assign bus.err_gap   = r_err_gap;

`ifdef FFT_CTRL_BITREV_EN
  assign bus.out_bin_up = {1'b0, bitrev4(w_tout.cnt)};
  assign bus.out_bin_lo = {1'b1, bitrev4(w_tout.cnt)};
`endif

endmodule
